// File: rtl/detector_jogada_if.sv
// Button/play handshake bundle between the player input side and detector_jogada.
// master drives the raw buttons and enable; slave (the detector) returns the play outputs.
interface detector_jogada_if;
   logic       habilita;
   logic [3:0] botoes;
   logic       jogada;
   logic [3:0] jogada_valor;
   logic       ocupado;
   logic [1:0] db_estado;

   modport master (
      output habilita,
      output botoes,
      input  jogada,
      input  jogada_valor,
      input  ocupado,
      input  db_estado
   );

   modport slave (
      input  habilita,
      input  botoes,
      output jogada,
      output jogada_valor,
      output ocupado,
      output db_estado
   );
endinterface

// File: rtl/detector_jogada.sv
// Debounced single-button play detector: emits a one-cycle jogada pulse and a held one-hot value.
// Optional macro DETECTOR_JOGADA_SYNC_EN adds a 2-flop input synchronizer on botoes.
module detector_jogada #(
   parameter int unsigned DEBOUNCE_CICLOS = 4
) (
   input logic               clock,
   input logic               reset,
   detector_jogada_if.slave  io_det
);
   localparam int unsigned   CW     = $clog2(DEBOUNCE_CICLOS) + 1;
   localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CICLOS - 1);

   typedef enum logic [1:0] {
      StOcioso       = 2'b00,
      StFiltrando    = 2'b01,
      StPulso        = 2'b10,
      StEsperaSoltar = 2'b11
   } estado_t;

   estado_t       r_estado, w_estado_prox;
   logic [CW-1:0] r_cnt, w_cnt_prox;
   logic [3:0]    r_candidato, w_candidato_prox;
   logic [3:0]    r_valor, w_valor_prox;
   logic [3:0]    w_s;
   logic          w_valido;
   logic          w_solto;

`ifdef DETECTOR_JOGADA_SYNC_EN
   logic [3:0] r_sync1, r_sync2;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sync1 <= 4'b0000;
         r_sync2 <= 4'b0000;
      end else begin
         r_sync1 <= io_det.botoes;
         r_sync2 <= r_sync1;
      end
   end

   assign w_s = r_sync2;
`else
   assign w_s = io_det.botoes;
`endif

   assign w_solto  = (w_s == 4'b0000);
   // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
   assign w_valido = !w_solto && ((w_s & (w_s - 4'd1)) == 4'b0000);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_estado    <= StOcioso;
         r_cnt       <= '0;
         r_candidato <= 4'b0000;
         r_valor     <= 4'b0000;
      end else begin
         r_estado    <= w_estado_prox;
         r_cnt       <= w_cnt_prox;
         r_candidato <= w_candidato_prox;
         r_valor     <= w_valor_prox;
      end
   end

   always_comb begin
      w_estado_prox    = r_estado;
      w_cnt_prox       = r_cnt;
      w_candidato_prox = r_candidato;
      w_valor_prox     = r_valor;
      case (r_estado)
         StOcioso: begin
            if (io_det.habilita && w_valido) begin
               w_candidato_prox = w_s;
               w_cnt_prox       = '0;
               w_estado_prox    = StFiltrando;
            end
         end
         StFiltrando: begin
            if (!io_det.habilita || (w_s != r_candidato)) begin
               w_estado_prox = StOcioso;
            end else if (r_cnt == CntMax) begin
               w_valor_prox  = r_candidato;
               w_estado_prox = StPulso;
            end else begin
               w_cnt_prox = r_cnt + 1'b1;
            end
         end
         StPulso: begin
            w_cnt_prox    = '0;
            w_estado_prox = StEsperaSoltar;
         end
         StEsperaSoltar: begin
            // Any button seen, including a bounce, restarts the release filter.
            if (w_solto) begin
               if (r_cnt == CntMax) begin
                  w_cnt_prox    = '0;
                  w_estado_prox = StOcioso;
               end else begin
                  w_cnt_prox = r_cnt + 1'b1;
               end
            end else begin
               w_cnt_prox = '0;
            end
         end
         default: w_estado_prox = StOcioso;
      endcase
   end

   assign io_det.jogada       = (r_estado == StPulso);
   assign io_det.ocupado      = (r_estado != StOcioso);
   assign io_det.db_estado    = r_estado;
   assign io_det.jogada_valor = r_valor;
endmodule

// File: doc/detector_jogada.md
Name: detector_jogada

Overview:
- Input stage of the memory-game circuit, upstream of the game control unit.
- Turns the 4 raw player buttons into a single-cycle `jogada` pulse plus a registered one-hot `jogada_valor`. The control unit samples `jogada` in its wait state; the datapath compares `jogada_valor` against memory.
- Performs debounce, rejects simultaneous multi-button presses, and requires full release before the next play is accepted.

Parameters:
- DEBOUNCE_CICLOS, 4, consecutive stable cycles required to accept a press or a release. Legal values ≥1; 50000 on board at 50 MHz.
- CW, $clog2(DEBOUNCE_CICLOS)+1, debounce counter width (derived, not overridden).

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- habilita  input  1  presses accepted only while high
- botoes  input  4  raw buttons, active-high, bit i = button i
- jogada  output  1  one-cycle pulse: valid debounced play accepted
- jogada_valor  output  4  one-hot code of the last accepted play; holds until the next accept
- ocupado  output  1  high in every state except OCIOSO
- db_estado  output  2  current state code (debug)

Behaviour:
- Reset (async): state=OCIOSO, cnt=0, candidato=0, jogada=0, jogada_valor=4'b0000, ocupado=0, db_estado=2'b00.
- `s` = sampled buttons: `botoes` directly, or the synchronizer output (see Optional Feature).
- "valid" = `s` has exactly one bit set. "solto" = `s`==0.
- Moore FSM. Outputs are decoded from the state; `jogada_valor` is a register.
- State OCIOSO (00):
  - If habilita & valid: candidato<=s, cnt<=0, go to FILTRANDO.
  - Otherwise (including multi-bit `s`) stay in OCIOSO.
- State FILTRANDO (01):
  - If !habilita or s!=candidato: go to OCIOSO. A change of button, an added button, or a release all abort.
  - Else if cnt==DEBOUNCE_CICLOS-1: jogada_valor<=candidato, go to PULSO.
  - Else cnt<=cnt+1.
- State PULSO (10):
  - jogada=1 for exactly this one cycle.
  - Unconditionally: cnt<=0, go to ESPERA_SOLTAR.
- State ESPERA_SOLTAR (11):
  - If solto: cnt<=cnt+1; when cnt==DEBOUNCE_CICLOS-1, go to OCIOSO.
  - If any button is seen: cnt<=0 and stay (bounce restarts the release filter).
  - `habilita` is ignored here. A held button never generates a second play.
- Latency: `s` valid and stable from edge k ⇒ FILTRANDO after edge k, PULSO after edge k+DEBOUNCE_CICLOS. `jogada` is high in the cycle after that edge, i.e. DEBOUNCE_CICLOS+1 cycles after the first sampled press (no synchronizer).
- Counter never wraps: it is always cleared on entry to FILTRANDO and ESPERA_SOLTAR, and bounded by DEBOUNCE_CICLOS-1.
- `jogada_valor` is only ever 0 (after reset) or one-hot. It is unaffected by `habilita` and by aborted filters.
- A press held through `habilita` rising (OCIOSO, already pressed) is accepted only after a full debounce from the first enabled edge.
- Reset asserted mid-operation returns to OCIOSO immediately and clears `jogada_valor`. No `jogada` pulse is emitted on reset release.

Optional Feature:
- Macro: DETECTOR_JOGADA_SYNC_EN.
- Defined: `botoes` passes through a 2-flop synchronizer (reset to 0) before forming `s`. All latencies grow by 2 cycles; pulses shorter than 1 cycle may be lost.
- Undefined: `s`=`botoes` directly. `botoes` must already be synchronous to `clock` (simulation and testbench use).

Test Plan (DEBOUNCE_CICLOS=4, no sync macro unless stated):
1. reset, habilita=1, botoes=4'b0100 held 10 cycles → jogada high for exactly 1 cycle, 5 cycles after the press; jogada_valor=4'b0100; no further pulse while held.
2. botoes=4'b0010 for 2 cycles, 0 for 1 cycle, then 4'b0010 held → first burst aborted; single pulse 5 cycles after the last press starts; jogada_valor=4'b0010.
3. botoes=4'b0011 held 10 cycles → no jogada, state stays OCIOSO, jogada_valor unchanged.
4. Accept 4'b0001, then release with a 1-cycle 4'b0001 glitch after 2 released cycles, then 4'b1000 pressed 3 cycles after the glitch → release counter restarts; 4'b1000 ignored until 4 clean released cycles; then one pulse with jogada_valor=4'b1000.
5. habilita=0 with botoes=4'b0100 → no pulse. Raise habilita with the button held → pulse 5 cycles later. Assert reset during FILTRANDO → outputs return to reset values immediately.
6. DETECTOR_JOGADA_SYNC_EN defined, scenario 1 → pulse 7 cycles after the press, same jogada_valor.
